// File: rtl/barrel_shift_pipe_if.sv
// Operand/result bus of the pipelined barrel shifter.
// Handshake: a beat moves on any rising edge where valid && ready; the sender holds
// its payload while valid && !ready, and the receiver may drive ready independently.
interface barrel_shift_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic               in_dir;
  logic [1:0]         in_mode;
  logic [TAG_W-1:0]   in_tag;

  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_carry;
  logic [TAG_W-1:0]   out_tag;

  modport slave (
    input  in_valid, in_data, in_shamt, in_dir, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_tag
  );

  modport master (
    output in_valid, in_data, in_shamt, in_dir, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_tag
  );
endinterface

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter/rotator: stage k shifts by 2^k when shamt bit k is set.
// Per-stage valid bits with a combinational load chain let bubbles collapse under stall.
module barrel_shift_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  barrel_shift_pipe_if.slave   bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int LAST    = SHAMT_W - 1;

  logic [WIDTH-1:0]   data_q  [SHAMT_W];
  logic [SHAMT_W-1:0] shamt_q [SHAMT_W];
  logic [1:0]         mode_q  [SHAMT_W];
  logic [TAG_W-1:0]   tag_q   [SHAMT_W];
  logic [SHAMT_W-1:0] valid_q, dir_q, carry_q;

  logic [WIDTH-1:0]   data_d  [SHAMT_W];
  logic [SHAMT_W-1:0] valid_d;

  logic [WIDTH-1:0]   src_data  [SHAMT_W];
  logic [SHAMT_W-1:0] src_shamt [SHAMT_W];
  logic [1:0]         src_mode  [SHAMT_W];
  logic [TAG_W-1:0]   src_tag   [SHAMT_W];
  logic [SHAMT_W-1:0] src_dir, src_carry;

  logic [SHAMT_W-1:0] load;
  logic [SHAMT_W-1:0] neg_shamt;
  logic               in_carry;

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                input int unsigned    amt,
                                                input logic           dir,
                                                input logic [1:0]     mode);
    logic [WIDTH-1:0] r;
    if (mode[1])
      r = dir ? ((d << amt) | (d >> (WIDTH - amt))) : ((d >> amt) | (d << (WIDTH - amt)));
    else if (dir)
      r = d << amt;
    else if (mode[0])
      r = WIDTH'($signed(d) >>> amt);
    else
      r = d >> amt;
    return r;
  endfunction

  // Carry is the last bit to leave the word; WIDTH-s equals -s modulo WIDTH.
  always_comb begin
    neg_shamt = SHAMT_W'(0) - bus.in_shamt;
    if (bus.in_shamt == '0)
      in_carry = 1'b0;
    else if (bus.in_dir)
      in_carry = bus.in_data[neg_shamt];
    else
      in_carry = bus.in_data[bus.in_shamt - SHAMT_W'(1)];
  end

  always_comb begin
    logic run;
    run = bus.out_ready;
    load = '0;
    for (int k = LAST; k >= 0; k--) begin
      run     = !valid_q[k] || run;
      load[k] = run;
    end
  end

  always_comb begin
    src_data[0]  = bus.in_data;
    src_shamt[0] = bus.in_shamt;
    src_mode[0]  = bus.in_mode;
    src_tag[0]   = bus.in_tag;
    src_dir[0]   = bus.in_dir;
    src_carry[0] = in_carry;
    valid_d[0]   = bus.in_valid;
    for (int k = 1; k < SHAMT_W; k++) begin
      src_data[k]  = data_q[k-1];
      src_shamt[k] = shamt_q[k-1];
      src_mode[k]  = mode_q[k-1];
      src_tag[k]   = tag_q[k-1];
      src_dir[k]   = dir_q[k-1];
      src_carry[k] = carry_q[k-1];
      valid_d[k]   = valid_q[k-1];
    end
    for (int k = 0; k < SHAMT_W; k++) begin
      data_d[k] = src_shamt[k][k] ? shift_by(src_data[k], 1 << k, src_dir[k], src_mode[k])
                                  : src_data[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dir_q   <= '0;
      carry_q <= '0;
      for (int k = 0; k < SHAMT_W; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        mode_q[k]  <= '0;
        tag_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < SHAMT_W; k++) begin
        if (load[k]) begin
          valid_q[k] <= valid_d[k];
          data_q[k]  <= data_d[k];
          shamt_q[k] <= src_shamt[k];
          mode_q[k]  <= src_mode[k];
          tag_q[k]   <= src_tag[k];
          dir_q[k]   <= src_dir[k];
          carry_q[k] <= src_carry[k];
        end
      end
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = valid_q[LAST];
  assign bus.out_data  = data_q[LAST];
  assign bus.out_carry = carry_q[LAST];
  assign bus.out_tag   = tag_q[LAST];
endmodule
